// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount accumulator.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Bits needed to hold a count of 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/popcount_accum_if.sv
// Beat input / frame result handshake bundle for popcount_accum.
interface popcount_accum_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_last, mode, out_ready,
    input  in_ready, out_valid, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, mode, out_ready,
    output in_ready, out_valid, out_count, out_sat
  );
endinterface

// File: rtl/ones_counter_3.sv
// Counts the ones among three input bits (full adder): cnt = {carry, sum}.
module ones_counter_3 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [1:0] cnt
);
  assign cnt[0] = a ^ b ^ c;
  assign cnt[1] = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/popcount_accum.sv
// Per-frame ones/zeros counter: carry-save per-beat popcount feeding a saturating
// accumulator, with a held result on a valid/ready output.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  popcount_accum_if.slave  bus
);

  localparam int unsigned PCW = cnt_width(WIDTH);
  localparam int unsigned SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
  localparam logic [SW-1:0] MAX_SUM = SW'((64'd1 << CNT_W) - 64'd1);

  logic [WIDTH-1:0] x;
  logic [PCW-1:0]   pc;

  // Counting zeros is counting ones of the inverted beat.
  assign x = bus.in_data ^ {WIDTH{bus.mode}};

  // Each stage folds one more input bit into a (sum, carry) vector pair.
  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_stage
    logic [PCW-1:0] s;
    logic [PCW-1:0] c;
    if (i == 0) begin : g_first
      assign s = PCW'(x[0]);
      assign c = PCW'(x[1]);
    end else begin : g_csa
      for (genvar j = 0; j < PCW - 1; j++) begin : g_bit
        ones_counter_3 u_fa (
          .a  (g_stage[i-1].s[j]),
          .b  (g_stage[i-1].c[j]),
          .c  ((j == 0) ? x[i+1] : 1'b0),
          .cnt({c[j+1], s[j]})
        );
      end
      // Carry out of the top column cannot be set: the running total stays below 2^PCW.
      assign s[PCW-1] = g_stage[i-1].s[PCW-1] ^ g_stage[i-1].c[PCW-1];
      assign c[0]     = 1'b0;
    end
  end

  assign pc = g_stage[WIDTH-2].s + g_stage[WIDTH-2].c;

  state_e           state_q;
  logic [CNT_W-1:0] acc_q;
  logic             sat_flag_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_sat_q;

  logic [SW-1:0]    sum;
  logic             overflow;
  logic [CNT_W-1:0] sat_val;
  logic             accept;
  logic             take;

  assign sum      = SW'(acc_q) + SW'(pc);
  assign overflow = sum > MAX_SUM;
  assign sat_val  = overflow ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  assign bus.in_ready  = (state_q != HOLD) || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_sat   = out_sat_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign take   = out_valid_q && bus.out_ready;

  // An accept while in HOLD implies out_ready, so the held result is consumed too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (accept) begin
      if (bus.in_last) begin
        out_count_q <= sat_val;
        out_sat_q   <= sat_flag_q | overflow;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
        sat_flag_q  <= 1'b0;
        state_q     <= HOLD;
      end else begin
        acc_q       <= sat_val;
        sat_flag_q  <= sat_flag_q | overflow;
        out_valid_q <= 1'b0;
        state_q     <= ACCUM;
      end
    end else if (take) begin
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Scoreboard bench: directed frames push expected results, per-DUT monitors pop and compare.
module tb_popcount_accum;

  typedef struct {
    logic [31:0] cnt;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q8[$];
  exp_t q4[$];

  popcount_accum_if #(.WIDTH(8), .CNT_W(16)) b8 ();
  popcount_accum_if #(.WIDTH(8), .CNT_W(4))  b4 ();

  popcount_accum #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .bus(b8.slave)
  );

  popcount_accum #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk),
    .rst(rst),
    .bus(b4.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [31:0] cnt, input logic sat);
    exp_t e;
    e.cnt = cnt;
    e.sat = sat;
    if (sel) q4.push_back(e);
    else     q8.push_back(e);
  endtask

  // Present a beat, wait for acceptance (bounded), then withdraw it.
  task automatic send(input bit sel, input logic [7:0] d, input logic l, input logic m);
    bit done = 1'b0;
    if (sel) begin
      b4.in_valid = 1'b1; b4.in_data = d; b4.in_last = l; b4.mode = m;
    end else begin
      b8.in_valid = 1'b1; b8.in_data = d; b8.in_last = l; b8.mode = m;
    end
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (sel ? b4.in_ready : b8.in_ready) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end
    @(posedge clk);
    #1;
    if (sel) b4.in_valid = 1'b0;
    else     b8.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        check("unexpected_result8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("count8", 32'(b8.out_count), e.cnt);
        check("sat8", 32'(b8.out_sat), 32'(e.sat));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        check("unexpected_result4", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("count4", 32'(b4.out_count), e.cnt);
        check("sat4", 32'(b4.out_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    rst = 1'b1;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.in_last = 1'b0; b8.mode = 1'b0; b8.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_last = 1'b0; b4.mode = 1'b0; b4.out_ready = 1'b1;

    // Reset acts before any clock edge.
    #3;
    check("rst_out_valid", 32'(b8.out_valid), 32'd0);
    check("rst_out_count", 32'(b8.out_count), 32'd0);
    check("rst_out_sat", 32'(b8.out_sat), 32'd0);
    check("rst_in_ready", 32'(b8.in_ready), 32'd1);
    check("rst_in_ready4", 32'(b4.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-beat frame, one-cycle latency.
    push(1'b0, 32'd4, 1'b0);
    send(1'b0, 8'hA5, 1'b1, 1'b0);
    check("latency_out_valid", 32'(b8.out_valid), 32'd1);

    // Multi-beat frame starting while the previous result is being taken.
    push(1'b0, 32'd13, 1'b0);
    send(1'b0, 8'hFF, 1'b0, 1'b0);
    send(1'b0, 8'h0F, 1'b0, 1'b0);
    send(1'b0, 8'h01, 1'b1, 1'b0);

    // Mode switches per beat.
    push(1'b0, 32'd11, 1'b0);
    send(1'b0, 8'h01, 1'b0, 1'b1);
    send(1'b0, 8'hF0, 1'b1, 1'b0);

    // Back-pressure: result held, input stalled, then reload on the same cycle.
    push(1'b0, 32'd3, 1'b0);
    send(1'b0, 8'h07, 1'b1, 1'b0);
    b8.out_ready = 1'b0;
    b8.in_valid = 1'b1; b8.in_data = 8'h0F; b8.in_last = 1'b1; b8.mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_in_ready", 32'(b8.in_ready), 32'd0);
      check("hold_out_valid", 32'(b8.out_valid), 32'd1);
      check("hold_out_count", 32'(b8.out_count), 32'd3);
    end
    @(posedge clk);
    #1;
    b8.out_ready = 1'b1;
    push(1'b0, 32'd4, 1'b0);
    @(posedge clk);
    #1;
    check("reload_out_valid", 32'(b8.out_valid), 32'd1);
    b8.in_valid = 1'b0;

    // Reset mid-frame drops the partial count.
    send(1'b0, 8'hFF, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(b8.in_ready), 32'd1);
    check("midrst_out_valid", 32'(b8.out_valid), 32'd0);
    #1;
    rst = 1'b0;
    push(1'b0, 32'd1, 1'b0);
    send(1'b0, 8'h01, 1'b1, 1'b0);

    // Zero counting extremes.
    push(1'b0, 32'd8, 1'b0);
    send(1'b0, 8'h00, 1'b1, 1'b1);
    push(1'b0, 32'd0, 1'b0);
    send(1'b0, 8'hFF, 1'b1, 1'b1);

    // Narrow accumulator: saturation, clean next frame, exact-max without saturation.
    push(1'b1, 32'd15, 1'b1);
    send(1'b1, 8'hFF, 1'b0, 1'b0);
    send(1'b1, 8'hFF, 1'b0, 1'b0);
    send(1'b1, 8'hFF, 1'b1, 1'b0);
    push(1'b1, 32'd2, 1'b0);
    send(1'b1, 8'h03, 1'b1, 1'b0);
    push(1'b1, 32'd15, 1'b0);
    send(1'b1, 8'hFF, 1'b0, 1'b0);
    send(1'b1, 8'h7F, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("pending8", 32'(q8.size()), 32'd0);
    check("pending4", 32'(q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
